// File: rtl/arm_pkg.sv
// Shared ARM register-file definitions: mode encodings, register numbers and
// the 31-entry physical register index map.
package arm_pkg;

    typedef enum logic [2:0] {
        MODE_USR = 3'd0,
        MODE_FIQ = 3'd1,
        MODE_IRQ = 3'd2,
        MODE_SVC = 3'd3,
        MODE_ABT = 3'd4,
        MODE_UND = 3'd5,
        MODE_SYS = 3'd6,
        MODE_RSV = 3'd7
    } mode_e;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    localparam int unsigned NUM_PHYS = 31;

    // USR/SYS R0-R15 occupy 0-15; banked copies follow in mode order.
    typedef enum logic [4:0] {
        P_R0, P_R1, P_R2, P_R3, P_R4, P_R5, P_R6, P_R7,
        P_R8, P_R9, P_R10, P_R11, P_R12, P_R13, P_R14, P_R15,
        P_FIQ_R8, P_FIQ_R9, P_FIQ_R10, P_FIQ_R11, P_FIQ_R12, P_FIQ_R13, P_FIQ_R14,
        P_IRQ_R13, P_IRQ_R14,
        P_SVC_R13, P_SVC_R14,
        P_ABT_R13, P_ABT_R14,
        P_UND_R13, P_UND_R14
    } phys_e;

    // R13 is odd and R14 even, so the low address bit selects within a pair.
    function automatic logic [4:0] pair_idx(input phys_e base, input logic [3:0] addr);
        return base + {4'b0000, ~addr[0]};
    endfunction

endpackage

// File: rtl/bank_map.sv
// Combinational mapping of (mode, user_bank, logical register) to a physical
// register index.
module bank_map
    import arm_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       user_bank,
    input  logic [3:0] addr,
    output logic [4:0] phys
);

    mode_e eff;
    logic  is_sp_lr;

    assign is_sp_lr = (addr == REG_SP) || (addr == REG_LR);

    always_comb begin
        eff = mode_e'(mode);
        if (user_bank || eff == MODE_SYS || eff == MODE_RSV)
            eff = MODE_USR;

        phys = {1'b0, addr};
        case (eff)
            MODE_FIQ: if (addr[3] && addr != REG_PC) phys = P_FIQ_R8 + {2'b00, addr[2:0]};
            MODE_IRQ: if (is_sp_lr) phys = pair_idx(P_IRQ_R13, addr);
            MODE_SVC: if (is_sp_lr) phys = pair_idx(P_SVC_R13, addr);
            MODE_ABT: if (is_sp_lr) phys = pair_idx(P_ABT_R13, addr);
            MODE_UND: if (is_sp_lr) phys = pair_idx(P_UND_R13, addr);
            default: ;
        endcase
    end

endmodule

// File: rtl/banked_reg_file.sv
// ARM-style banked register file: 31 physical registers, NUM_RD combinational
// read ports, two write ports (wa wins over wb) and an auto-incrementing R15.
module banked_reg_file
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               mode,
    input  logic                     user_bank,
    input  logic [4*NUM_RD-1:0]      rd_addr,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    input  logic                     wa_en,
    input  logic [3:0]               wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [3:0]               wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     pc_inc,
    output logic [DATA_W-1:0]        pc,
    output logic [DATA_W-1:0]        sp,
    output logic [DATA_W-1:0]        lr,
    output logic                     mode_err
);

    // Read views: NUM_RD ports followed by sp, lr and pc.
    localparam int unsigned NUM_VIEW = NUM_RD + 3;

    logic [DATA_W-1:0] regs      [NUM_PHYS];
    logic [DATA_W-1:0] nxt       [NUM_PHYS];
    logic [4:0]        view_phys [NUM_VIEW];
    logic [DATA_W-1:0] view_data [NUM_VIEW];
    logic [4:0]        wa_phys, wb_phys;
    logic              wa_we, wb_we;

    assign wa_we = wa_en & rst_n;
    assign wb_we = wb_en & rst_n;

    bank_map u_wa_map (.mode(mode), .user_bank(user_bank), .addr(wa_addr), .phys(wa_phys));
    bank_map u_wb_map (.mode(mode), .user_bank(user_bank), .addr(wb_addr), .phys(wb_phys));

    // sp/lr always reflect the current mode, independent of user_bank.
    bank_map u_sp_map (.mode(mode), .user_bank(1'b0), .addr(REG_SP), .phys(view_phys[NUM_RD]));
    bank_map u_lr_map (.mode(mode), .user_bank(1'b0), .addr(REG_LR), .phys(view_phys[NUM_RD+1]));
    assign view_phys[NUM_RD+2] = P_R15;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_map
        bank_map u_rd_map (
            .mode     (mode),
            .user_bank(user_bank),
            .addr     (rd_addr[4*g +: 4]),
            .phys     (view_phys[g])
        );
        assign rd_data[DATA_W*g +: DATA_W] = view_data[g];
    end

    for (genvar g = 0; g < NUM_VIEW; g++) begin : g_view
        always_comb begin
            view_data[g] = regs[view_phys[g]];
            if (BYPASS != 0) begin
                if (wa_we && wa_phys == view_phys[g])
                    view_data[g] = wa_data;
                else if (wb_we && wb_phys == view_phys[g])
                    view_data[g] = wb_data;
            end
        end
    end

    assign sp = view_data[NUM_RD];
    assign lr = view_data[NUM_RD+1];
    assign pc = view_data[NUM_RD+2];

    // Later assignments take priority: explicit writes beat pc_inc, wa beats wb.
    always_comb begin
        nxt = regs;
        if (pc_inc)
            nxt[P_R15] = regs[P_R15] + DATA_W'(PC_STEP);
        if (wb_en)
            nxt[wb_phys] = wb_data;
        if (wa_en)
            nxt[wa_phys] = wa_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PHYS; i++)
                regs[i] <= '0;
            regs[P_R15] <= DATA_W'(RESET_PC);
            mode_err    <= 1'b0;
        end else begin
            regs <= nxt;
            if (mode_e'(mode) == MODE_RSV)
                mode_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_banked_reg_file.sv
// Scoreboard bench for banked_reg_file: a reference model predicts every
// read view before each clock edge; directed scenarios add fixed-value checks.
module tb_banked_reg_file;

    localparam int unsigned DW  = 32;
    localparam int unsigned NRD = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        mode;
    logic              user_bank;
    logic [4*NRD-1:0]  rd_addr;
    logic [DW*NRD-1:0] rd_data;
    logic              wa_en, wb_en, pc_inc;
    logic [3:0]        wa_addr, wb_addr;
    logic [DW-1:0]     wa_data, wb_data;
    logic [DW-1:0]     pc, sp, lr;
    logic              mode_err;

    always #5 clk = ~clk;

    banked_reg_file #(
        .DATA_W  (DW),
        .NUM_RD  (NRD),
        .RESET_PC(32'h100),
        .PC_STEP (4),
        .BYPASS  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .user_bank(user_bank),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .pc_inc   (pc_inc),
        .pc       (pc),
        .sp       (sp),
        .lr       (lr),
        .mode_err (mode_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mdl [31];
    logic        mdl_err;

    typedef struct packed {
        logic [31:0] r0, r1, r2, pc, sp, lr;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int tb_phys(input logic [2:0] m, input logic ub, input logic [3:0] a);
        int em;
        em = (ub || m >= 3'd6) ? 0 : int'(m);
        if (a < 4'd8 || a == 4'd15) return int'(a);
        if (em == 1) return 8 + int'(a);
        if (a >= 4'd13 && em >= 2) return 23 + (em - 2) * 2 + (int'(a) - 13);
        return int'(a);
    endfunction

    function automatic logic [31:0] tb_view(input int p);
        if (rst_n && wa_en && tb_phys(mode, user_bank, wa_addr) == p) return wa_data;
        if (rst_n && wb_en && tb_phys(mode, user_bank, wb_addr) == p) return wb_data;
        return mdl[p];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 31; i++) mdl[i] = '0;
        mdl[15] = 32'h100;
        mdl_err = 1'b0;
    endtask

    task automatic mdl_clock();
        if (!rst_n) begin
            mdl_reset();
        end else begin
            if (pc_inc) mdl[15] = mdl[15] + 32'd4;
            if (wb_en) mdl[tb_phys(mode, user_bank, wb_addr)] = wb_data;
            if (wa_en) mdl[tb_phys(mode, user_bank, wa_addr)] = wa_data;
            if (mode == 3'd7) mdl_err = 1'b1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.r0  = tb_view(tb_phys(mode, user_bank, rd_addr[3:0]));
        e.r1  = tb_view(tb_phys(mode, user_bank, rd_addr[7:4]));
        e.r2  = tb_view(tb_phys(mode, user_bank, rd_addr[11:8]));
        e.pc  = tb_view(15);
        e.sp  = tb_view(tb_phys(mode, 1'b0, 4'd13));
        e.lr  = tb_view(tb_phys(mode, 1'b0, 4'd14));
        e.err = mdl_err;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        check_val("rd0", rd_data[31:0], e.r0);
        check_val("rd1", rd_data[63:32], e.r1);
        check_val("rd2", rd_data[95:64], e.r2);
        check_val("pc", pc, e.pc);
        check_val("sp", sp, e.sp);
        check_val("lr", lr, e.lr);
        check_val("mode_err", {31'b0, mode_err}, {31'b0, e.err});
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        push_exp();
        #2;
        pop_cmp();
        @(posedge clk);
        mdl_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        pc_inc = 1'b0;
    endtask

    task automatic write_a(input logic [3:0] a, input logic [31:0] d);
        wa_en   = 1'b1;
        wa_addr = a;
        wa_data = d;
    endtask

    initial begin
        rst_n = 1'b0; mode = 3'd0; user_bank = 1'b0; rd_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; pc_inc = 1'b0;
        mdl_reset();
        @(negedge clk);

        rd_addr = {4'd15, 4'd5, 4'd0};
        step();
        #1 check_val("rst_pc", pc, 32'h100);
        check_val("rst_r5", rd_data[63:32], 32'h0);
        rst_n = 1'b1;
        step();

        // Banked R13 in SVC and IRQ
        rd_addr = {4'd14, 4'd13, 4'd13};
        mode = 3'd3; write_a(4'd13, 32'hAAAA); step();
        mode = 3'd2; write_a(4'd13, 32'hBBBB); step();
        idle();
        mode = 3'd3; #1 check_val("svc_sp", sp, 32'hAAAA); step();
        mode = 3'd2; #1 check_val("irq_sp", sp, 32'hBBBB); step();
        mode = 3'd0; #1 check_val("usr_r13", rd_data[31:0], 32'h0); step();

        // FIQ R8
        rd_addr = {4'd9, 4'd13, 4'd8};
        mode = 3'd1; write_a(4'd8, 32'd5); step();
        idle();
        mode = 3'd0; #1 check_val("usr_r8", rd_data[31:0], 32'h0); step();
        mode = 3'd1; user_bank = 1'b1; #1 check_val("ub_r8", rd_data[31:0], 32'h0); step();
        user_bank = 1'b0; #1 check_val("fiq_r8", rd_data[31:0], 32'd5); step();

        // Same-register write conflict
        mode = 3'd0; rd_addr = {4'd15, 4'd4, 4'd3};
        write_a(4'd3, 32'd7);
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'd9;
        #1 check_val("conf_byp", rd_data[31:0], 32'd7); step();
        idle(); #1 check_val("conf_r3", rd_data[31:0], 32'd7); step();

        // PC wrap and write priority over pc_inc
        write_a(4'd15, 32'hFFFF_FFFC); step();
        idle(); pc_inc = 1'b1; step();
        idle(); #1 check_val("pc_wrap", pc, 32'h0);
        pc_inc = 1'b1; write_a(4'd15, 32'h40); step();
        idle(); #1 check_val("pc_wa", pc, 32'h40);
        pc_inc = 1'b1; wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h80; step();
        idle(); pc_inc = 1'b1; step(); step();
        idle(); #1 check_val("pc_inc2", pc, 32'h88);

        // Reserved mode maps to USR and sets the sticky error
        rd_addr = {4'd14, 4'd13, 4'd8};
        mode = 3'd7; step();
        mode = 3'd0; step();
        #1 check_val("err_sticky", {31'b0, mode_err}, 32'h1);

        for (int i = 0; i < 300; i++) begin
            mode      = 3'($urandom_range(0, 7));
            user_bank = ($urandom_range(0, 7) == 0);
            rd_addr   = 12'($urandom);
            wa_en     = 1'($urandom);
            wa_addr   = 4'($urandom);
            wa_data   = $urandom;
            wb_en     = 1'($urandom);
            wb_addr   = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom);
            wb_data   = $urandom;
            pc_inc    = 1'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a write
        idle(); mode = 3'd0; user_bank = 1'b0;
        write_a(4'd4, 32'h1234); step();
        rd_addr = {4'd15, 4'd13, 4'd4};
        write_a(4'd4, 32'h55); pc_inc = 1'b1;
        #3 rst_n = 1'b0;
        mdl_reset();
        #1 push_exp(); pop_cmp();
        check_val("ar_r4", rd_data[31:0], 32'h0);
        @(posedge clk); mdl_clock();
        @(negedge clk);
        push_exp(); #1 pop_cmp();
        rst_n = 1'b1; idle();
        step();
        #1 check_val("ar_after", rd_data[31:0], 32'h0);
        check_val("ar_pc", pc, 32'h100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_RD, default 3: number of read ports.
REQ-003 SHALL have parameter RESET_PC, default 0: R15 value after reset.
REQ-004 SHALL have parameter PC_STEP, default 4: R15 auto-increment amount.
REQ-005 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle writes to the read ports.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 mode  in  3  current mode: 0 USR, 1 FIQ, 2 IRQ, 3 SVC, 4 ABT, 5 UND, 6 SYS, 7 reserved.
REQ-009 user_bank  in  1  forces all reads and writes to the USR view (LDM/STM with ^).
REQ-010 rd_addr  in  4*NUM_RD  packed logical read addresses.
REQ-011 rd_data  out  DATA_W*NUM_RD  packed read data.
REQ-012 wa_en, wa_addr[3:0], wa_data[DATA_W-1:0]  in  primary (Rd) write port.
REQ-013 wb_en, wb_addr[3:0], wb_data[DATA_W-1:0]  in  base-writeback write port.
REQ-014 pc_inc  in  1  advance R15 by PC_STEP.
REQ-015 pc, sp, lr  out  DATA_W each  R15 and the current-mode R13 and R14.
REQ-016 mode_err  out  1  sticky flag, set when mode==7 is seen.

Function
REQ-017 SHALL hold 31 physical registers:
- R0-R15 (USR/SYS);
- FIQ R8-R14;
- R13-R14 for each of IRQ, SVC, ABT and UND.
REQ-018 SHALL map each logical address to a physical register using the effective mode; effective mode is USR when user_bank=1 or mode is 6 or 7.
REQ-019 Reads SHALL be combinational from the physical registers.
REQ-020 With BYPASS=1, a read whose physical target is being written this cycle SHALL return the winning write data.
REQ-021 With BYPASS=0, reads SHALL return the pre-edge value.
REQ-022 Writes SHALL take effect on the rising edge after enable is sampled high: one-cycle latency.
REQ-023 When wa and wb target the same physical register, wa SHALL win and the wb write to it SHALL be discarded.
REQ-024 An explicit write to R15 from either port SHALL override pc_inc in that cycle.
REQ-025 Otherwise, pc_inc=1 SHALL set R15 to R15+PC_STEP, wrapping modulo 2^DATA_W.
REQ-026 A mode change SHALL take effect combinationally on reads and writes in the same cycle; no banked data SHALL be copied or lost.
REQ-027 sp, lr and pc SHALL follow the bypass rule of REQ-020/REQ-021.
REQ-028 mode_err SHALL set on the first edge with mode==7 and clear only on reset.

Reset
REQ-029 On rst_n low, all physical registers except R15 SHALL clear to 0, regardless of clk.
REQ-030 On rst_n low, R15 SHALL load RESET_PC and mode_err SHALL clear to 0.
REQ-031 Writes and pc_inc SHALL be ignored while rst_n is low.
REQ-032 Deassertion mid-operation SHALL leave no partial write; the first update occurs on the first rising edge with rst_n high.

Structure
REQ-033 SHALL take the mode encodings, physical-index constants (31 entries) and the register-number constants SP=13, LR=14, PC=15 from the shared package arm_pkg.
REQ-034 SHALL use one sub-module, bank_map: combinational mapping of (mode, user_bank, logical addr) to a 5-bit physical index, instantiated per read port and per write port.

Verification
REQ-035 Reset:
- stimulus: assert rst_n=0 with RESET_PC=0x100;
- required response: pc=0x100, all reads return 0, mode_err=0.
REQ-036 Banking:
- stimulus: in SVC write R13=0xAAAA; switch to IRQ and write R13=0xBBBB; return to SVC;
- required response: sp=0xAAAA in SVC, sp=0xBBBB in IRQ, USR R13=0.
REQ-037 FIQ:
- stimulus: in FIQ write R8=5; read R8 in USR; read R8 again with user_bank=1 while in FIQ;
- required response: 0 in USR, 0 with user_bank=1, 5 in FIQ.
REQ-038 Write conflict:
- stimulus: wa and wb both write R3, wa=7 and wb=9, in the same cycle;
- required response: R3=7; with BYPASS=1, rd_data shows 7 in that cycle.
REQ-039 PC priority:
- stimulus: pc=0xFFFFFFFC with pc_inc;
- required response: pc=0 (wrap).
- stimulus: pc_inc together with wa_addr=15, wa_data=0x40;
- required response: pc=0x40.
REQ-040 Async reset:
- stimulus: assert rst_n mid-cycle while wa_en=1;
- required response: registers clear immediately and the write is dropped.
